// File: rtl/ticket_buyer_ds.sv
// Customer-side bill driver for the ticket machine with a shadow
// credit model, event counters and a sticky protocol-mismatch flag.
module ticket_buyer_ds #(
  parameter int   DEPTH = 8,
  parameter int   CW    = 8,
  parameter logic ON    = 1'b1,
  parameter logic OFF   = 1'b0
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   go,
  input  logic                   push_valid,
  input  logic                   push_twenty,
  output logic                   push_ready,
  input  logic                   ready,
  input  logic                   bill,
  input  logic                   dispense,
  input  logic                   return_sig,
  output logic                   ten,
  output logic                   twenty,
  output logic [5:0]             credit,
  output logic                   busy,
  output logic [CW-1:0]          tickets,
  output logic [CW-1:0]          returns,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_RDY  = 3'd0,
    S_B10  = 3'd1,
    S_B20  = 3'd2,
    S_B30  = 3'd3,
    S_DISP = 3'd4,
    S_RTN  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q;
  logic [AW-1:0]   wr_q, rd_q;
  logic            mem_q [DEPTH];
  logic            err_q;
  logic [CW-1:0]   tk_q, rt_q;

  logic            full, empty, push, pop, head;
  logic            can_take, issue, mism;
  logic [3:0]      obs, exp_v;

  assign full       = (cnt_q == FULL);
  assign empty      = (cnt_q == '0);
  assign push_ready = !full;
  assign push       = push_valid && !full;
  assign head       = mem_q[rd_q];
  assign pop        = issue;

  assign can_take = (state_q == S_RDY) || (state_q == S_B10) ||
                    (state_q == S_B20) || (state_q == S_B30);
  assign issue = go && !empty && !err_q && !clear && can_take &&
                 ((ready == ON) || (bill == ON));

  assign ten    = (issue && !head) ? ON : OFF;
  assign twenty = (issue &&  head) ? ON : OFF;

  always_comb begin
    state_d = state_q;
    exp_v   = {OFF, OFF, OFF, OFF};
    credit  = 6'd0;
    unique case (state_q)
      S_RDY: begin
        exp_v  = {ON, OFF, OFF, OFF};
        credit = 6'd0;
        if (issue) state_d = head ? S_B20 : S_B10;
      end
      S_B10: begin
        exp_v  = {OFF, ON, OFF, OFF};
        credit = 6'd10;
        if (issue) state_d = head ? S_B30 : S_B20;
      end
      S_B20: begin
        exp_v  = {OFF, ON, OFF, OFF};
        credit = 6'd20;
        if (issue) state_d = head ? S_DISP : S_B30;
      end
      S_B30: begin
        exp_v  = {OFF, ON, OFF, OFF};
        credit = 6'd30;
        if (issue) state_d = head ? S_RTN : S_DISP;
      end
      S_DISP: begin
        exp_v   = {OFF, OFF, ON, OFF};
        credit  = 6'd40;
        state_d = S_RDY;
      end
      S_RTN: begin
        exp_v   = {OFF, OFF, OFF, ON};
        credit  = 6'd50;
        state_d = S_RDY;
      end
      default: state_d = S_RDY;
    endcase
  end

  assign obs  = {ready, bill, dispense, return_sig};
  assign mism = (obs != exp_v);
  assign busy = (state_q != S_RDY);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_RDY;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      tk_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (mism) err_q <= 1'b1;
      // counters stick at all-ones
      if (state_q == S_DISP && dispense == ON && !(&tk_q))
        tk_q <= tk_q + 1'b1;
      if (state_q == S_RTN && return_sig == ON && !(&rt_q))
        rt_q <= rt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= push_twenty;
  end

  assign tickets    = tk_q;
  assign returns    = rt_q;
  assign fifo_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ticket_buyer_ds.sv
// Bench for ticket_buyer_ds: behavioural ticket machine plus a
// credit-arithmetic reference model checked every cycle.
module tb_ticket_buyer_ds;

  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic clk, clear, go, push_valid, push_twenty, push_ready;
  logic ready, bill, dispense, return_sig, ten, twenty;
  logic [5:0] credit;
  logic busy, err;
  logic [CW-1:0] tickets, returns;
  logic [3:0] fifo_count;

  ticket_buyer_ds #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clear(clear), .go(go),
    .push_valid(push_valid), .push_twenty(push_twenty),
    .push_ready(push_ready),
    .ready(ready), .bill(bill), .dispense(dispense),
    .return_sig(return_sig),
    .ten(ten), .twenty(twenty), .credit(credit), .busy(busy),
    .tickets(tickets), .returns(returns),
    .fifo_count(fifo_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ticket machine
  int mc;
  bit force_disp;
  assign ready      = (mc == 0);
  assign bill       = (mc > 0) && (mc < 40);
  assign dispense   = (mc == 40) || force_disp;
  assign return_sig = (mc == 50);

  always @(posedge clk) begin
    if (clear)          mc <= 0;
    else if (mc >= 40)  mc <= 0;
    else if (ten)       mc <= mc + 10;
    else if (twenty)    mc <= mc + 20;
  end

  // reference model
  int m_cred, m_tk, m_rt;
  bit m_err;
  bit q[$];
  int n_chk, n_pass, n_ten, n_tw;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic step(input bit pv, input bit pt);
    bit iss, hd, mism, acc;
    push_valid  = pv;
    push_twenty = pt;
    #1;
    hd  = (q.size() > 0) ? q[0] : 1'b0;
    iss = go && q.size() > 0 && !m_err && !clear &&
          m_cred < 40 && (ready || bill);
    chk("ten",        ten,        iss && !hd);
    chk("twenty",     twenty,     iss && hd);
    chk("credit",     credit,     m_cred);
    chk("busy",       busy,       m_cred != 0);
    chk("tickets",    tickets,    m_tk);
    chk("returns",    returns,    m_rt);
    chk("fifo_count", fifo_count, q.size());
    chk("push_ready", push_ready, q.size() < DEPTH);
    chk("err",        err,        m_err);
    if (ten === 1'b1)    n_ten++;
    if (twenty === 1'b1) n_tw++;
    mism = (ready != (m_cred == 0)) ||
           (bill != (m_cred > 0 && m_cred < 40)) ||
           (dispense != (m_cred == 40)) ||
           (return_sig != (m_cred == 50));
    acc = pv && q.size() < DEPTH;
    if (clear) begin
      m_cred = 0; m_tk = 0; m_rt = 0; m_err = 0;
      q.delete();
    end else begin
      if (m_cred == 40 && dispense)   m_tk = sat(m_tk);
      if (m_cred == 50 && return_sig) m_rt = sat(m_rt);
      if (mism) m_err = 1;
      if (m_cred >= 40)  m_cred = 0;
      else if (iss)      m_cred += hd ? 20 : 10;
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(pt);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
  endtask

  typedef struct {
    int       n;
    bit [4:0] b;   // bit i = 1 means twenty
    int       t;
    int       r;
    int       c;
  } vec_t;

  vec_t tbl[6];
  int   t0;

  initial begin
    tbl[0] = '{4, 5'b00000, 1, 0, 0};   // 10,10,10,10
    tbl[1] = '{3, 5'b00111, 1, 0, 20};  // 20,20,20
    tbl[2] = '{4, 5'b01000, 0, 1, 0};   // 10,10,10,20
    tbl[3] = '{3, 5'b00101, 0, 1, 0};   // 20,10,20
    tbl[4] = '{3, 5'b00010, 1, 0, 0};   // 10,20,10
    tbl[5] = '{5, 5'b11011, 1, 1, 0};   // 20,20,10,20,20

    n_chk = 0; n_pass = 0; n_ten = 0; n_tw = 0;
    force_disp = 0; go = 0;
    push_valid = 0; push_twenty = 0;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_cred = 0; m_tk = 0; m_rt = 0; m_err = 0;
    q.delete();
    do_clear();

    for (int v = 0; v < 6; v++) begin
      do_clear();
      go = 1'b1;
      for (int i = 0; i < tbl[v].n; i++) step(1'b1, tbl[v].b[i]);
      repeat (8) step(1'b0, 1'b0);
      chk($sformatf("tbl%0d_tickets", v), tickets, tbl[v].t);
      chk($sformatf("tbl%0d_returns", v), returns, tbl[v].r);
      chk($sformatf("tbl%0d_credit", v),  credit,  tbl[v].c);
      chk($sformatf("tbl%0d_err", v),     err,     0);
    end

    // fill past capacity with issue disabled
    do_clear();
    go = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("full_count", fifo_count, 8);
    chk("full_ready", push_ready, 0);
    t0 = n_ten;
    go = 1'b1;
    repeat (16) step(1'b0, 1'b0);
    chk("full_pulses", n_ten - t0, 8);
    chk("full_tickets", tickets, 2);

    // machine misbehaves while credit is 20
    do_clear();
    go = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("b20_credit", credit, 20);
    force_disp = 1;
    step(1'b1, 1'b0);
    force_disp = 0;
    chk("err_set", err, 1);
    t0 = n_ten + n_tw;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("err_no_issue", n_ten + n_tw - t0, 0);
    chk("err_hold_credit", credit, 20);
    do_clear();
    chk("err_cleared", err, 0);

    // clear in the middle of a purchase
    do_clear();
    go = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    clear = 1'b1;
    #1;
    chk("clr_ten_off",    ten,    0);
    chk("clr_twenty_off", twenty, 0);
    step(1'b0, 1'b0);
    clear = 1'b0;
    chk("clr_credit", credit,     0);
    chk("clr_count",  fifo_count, 0);
    chk("clr_tk",     tickets,    0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("clr_restart", credit, 20);

    // randomized traffic
    do_clear();
    for (int i = 0; i < 400; i++) begin
      go    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)));
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
